boron_sbox_layer_serial: RTL and testbench
==========================================

Name: boron_sbox_layer_serial

Overview:
- Nibble-serial BORON substitution layer: accepts a 64-bit round state, passes it LANES nibbles per cycle through boron_gate S-box cells, and returns the fully substituted 64-bit state.
- Sits between the round-key-addition stage (upstream) and the block-shuffle/permutation stage (downstream) of the iterative BORON round datapath.
- Trades latency for area against a fully parallel 16-S-box layer.
- valid/ready handshake on both sides.

Parameters:
- LANES, 4, S-box cells instantiated and nibbles processed per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- NCYC, 16/LANES, derived localparam: processing cycles per block.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  64  state; nibble i = bits [4i+3:4i], bit 4i+3 drives S-box x3.
- out_valid  output  1  substituted state available.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  64  substituted state; nibble i = S(in nibble i).
- busy  output  1  high in RUN or HOLD.

Behaviour:
- S-box: S(0..F) = E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6; bit-exact with boron_gate.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: load in_data into working register, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the LANES least-significant working nibbles feed the S-box cells.
  - Working register shifts right by 4*LANES; the S-box outputs enter at the top 4*LANES bits.
  - cnt increments; at cnt==NCYC-1 the final result is registered into out_data and the FSM goes to HOLD.
- Latency: acceptance at edge k means out_valid=1 after edge k+NCYC. LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- HOLD:
  - out_valid=1; out_data stable until handshake.
  - out_valid&out_ready without a simultaneous new input: go to IDLE, out_valid<=0.
  - in_ready = out_ready in HOLD, for bubble-free back-to-back operation. out_ready&in_valid in the same cycle: output handshake completes, new state loads, go directly to RUN.
- in_data and in_valid are ignored outside acceptance cycles. out_ready is ignored outside HOLD.
- out_data is updated only on entry to HOLD. It retains its last value after the handshake.
- Reset (any state, including mid-RUN): FSM=IDLE, cnt=0, working register=0, out_data=64'h0, out_valid=0, busy=0. in_ready=1 in the first cycle after rst deasserts. A partially processed block is discarded, never emitted.
- rst has priority over every handshake in the same cycle.
- No combinational path from in_data to out_data. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Package boron_pkg:
  - BLOCK_W=64, NIBBLE_W=4, NUM_NIBBLES=16.
  - FSM state enum (IDLE/RUN/HOLD).
  - SBOX constant table, used by the testbench reference model only; RTL uses the gate cells.
- Sub-module: boron_gate, the existing 4-bit S-box cell, instantiated LANES times via generate.
- No other hierarchy.

Test Plan:
- LANES=4; in_data=64'h0, out_ready=1 -> after 4 cycles out_valid=1, out_data=64'hEEEE_EEEE_EEEE_EEEE; back to IDLE next cycle.
- LANES=1 and LANES=16; in_data=64'h0123_4567_89AB_CDEF -> out_data=64'hE4B1_79CA_D20F_8536 after 16 and 1 cycles respectively.
- LANES=4; out_ready=0 for 10 cycles after completion -> out_valid held, out_data stable, in_ready=0, further in_valid ignored. Then out_ready=1 -> one handshake only.
- Back-to-back: second in_data=64'hFEDC_BA98_7654_3210 presented while HOLD with out_ready=1 -> first result 64'hE4B1_79CA_D20F_8536 transfers, second accepted the same cycle, result 64'h6358_F02D_AC97_1B4E after NCYC cycles, no idle bubble.
- rst asserted at cnt==2 of RUN -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1. The discarded block is never output. A subsequent block computes correctly.
- Random 1000 blocks with random in_valid/out_ready stalls against the SBOX-table model -> zero mismatches, no dropped or duplicated blocks.

Source files
------------

// File: rtl/boron_pkg.sv
// boron_pkg: shared constants and types for the BORON substitution layer.
//   BLOCK_W / NIBBLE_W / NUM_NIBBLES : state geometry (64-bit state, 16 nibbles)
//   state_t                          : control FSM states of the serial layer
//   SBOX_TABLE / sbox_lookup         : reference S-box, nibble i of the table = S(i);
//                                      the datapath itself uses boron_gate cells
package boron_pkg;

    localparam int BLOCK_W     = 64;
    localparam int NIBBLE_W    = 4;
    localparam int NUM_NIBBLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    // S(0..F) = E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6 packed with S(0) in the low nibble
    localparam logic [BLOCK_W-1:0] SBOX_TABLE = 64'h6358_F02D_AC97_1B4E;

    function automatic logic [NIBBLE_W-1:0] sbox_lookup(input logic [NIBBLE_W-1:0] n);
        return SBOX_TABLE[NIBBLE_W*n +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/boron_gate.sv
// boron_gate: single 4-bit BORON S-box cell, purely combinational.
//   x : input nibble, x[3] is the S-box x3 input (most significant)
//   y : substituted nibble
module boron_gate (
    input  logic [3:0] x,
    output logic [3:0] y
);

    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hB;
            4'h3: y = 4'h1;
            4'h4: y = 4'h7;
            4'h5: y = 4'h9;
            4'h6: y = 4'hC;
            4'h7: y = 4'hA;
            4'h8: y = 4'hD;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'hF;
            4'hC: y = 4'h8;
            4'hD: y = 4'h5;
            4'hE: y = 4'h3;
            4'hF: y = 4'h6;
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/boron_sbox_layer_serial.sv
// boron_sbox_layer_serial: nibble-serial BORON substitution layer.
// A 64-bit state is accepted, rotated through LANES boron_gate cells per
// cycle for NCYC = 16/LANES cycles, and the substituted state is presented
// on out_data until the downstream handshake.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_data = 64-bit state
//   out_valid/out_ready : downstream handshake, out_data = substituted state
//   busy                : high while a block is being processed or held
module boron_sbox_layer_serial
    import boron_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int NCYC    = NUM_NIBBLES / LANES;
    localparam int SLICE_W = NIBBLE_W * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("boron_sbox_layer_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t               state;
    state_t               state_next;
    logic [BLOCK_W-1:0]   work;
    logic [BLOCK_W-1:0]   work_shifted;
    logic [SLICE_W-1:0]   sub_out;
    logic [4:0]           cnt;
    logic                 load;
    logic                 last;

    // The low LANES nibbles are substituted each cycle.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        boron_gate u_gate (
            .x (work[NIBBLE_W*g +: NIBBLE_W]),
            .y (sub_out[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    // Substituted nibbles re-enter at the top, so after NCYC shifts every
    // nibble is back in its original position.
    if (LANES == NUM_NIBBLES) begin : g_full
        assign work_shifted = sub_out;
    end else begin : g_part
        assign work_shifted = {sub_out, work[BLOCK_W-1:SLICE_W]};
    end

    assign last      = (state == RUN) && (cnt == 5'(NCYC - 1));
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = HOLD;
            end
            HOLD: begin
                // Accepting while the result drains keeps back-to-back blocks bubble-free.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (load) begin
                work <= in_data;
                cnt  <= '0;
            end else if (state == RUN) begin
                work <= work_shifted;
                cnt  <= cnt + 5'd1;
            end
            if (last) out_data <= work_shifted;
        end
    end

endmodule

// File: tb/tb_boron_sbox_layer_serial.sv
// tb_boron_sbox_layer_serial: self-checking bench for the serial S-box layer.
// Main instance uses LANES=4; two extra instances (LANES=1, LANES=16) check
// latency scaling. Expected results come from per-nibble table lookup.
module tb_boron_sbox_layer_serial;
    import boron_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_data, out_data;
    logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_busy;
    logic [63:0] v1_in_data, v1_out_data;
    logic        v16_in_valid, v16_in_ready, v16_out_valid, v16_out_ready, v16_busy;
    logic [63:0] v16_in_data, v16_out_data;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    boron_sbox_layer_serial #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    boron_sbox_layer_serial #(.LANES(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_data(v1_in_data),
        .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_data(v1_out_data),
        .busy(v1_busy)
    );

    boron_sbox_layer_serial #(.LANES(16)) dut_l16 (
        .clk(clk), .rst(rst),
        .in_valid(v16_in_valid), .in_ready(v16_in_ready), .in_data(v16_in_data),
        .out_valid(v16_out_valid), .out_ready(v16_out_ready), .out_data(v16_out_data),
        .busy(v16_busy)
    );

    function automatic logic [63:0] model(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_lookup(s[4*i +: 4]);
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_in_data = '0;
        v16_in_valid = 1'b0; v16_out_ready = 1'b0; v16_in_data = '0;
        step; step;
        rst = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (v1_out_valid !== 1'b0 || v16_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_variants: got %b/%b want 0/0", v1_out_valid, v16_out_valid);
        end
    endtask

    task automatic test_zero;
        int lat;
        in_data = 64'h0; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0; in_data = {$urandom, $urandom};
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin step; if (out_valid === 1'b1) lat = i; end
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL zero_latency: got %0d want 4", lat); end
        vectors++; if (out_data !== 64'hEEEE_EEEE_EEEE_EEEE) begin
            miscompares++; $display("FAIL zero_data: got %h want eeeeeeeeeeeeeeee", out_data);
        end
        step;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL zero_back_to_idle: got valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
        vectors++; if (out_data !== 64'hEEEE_EEEE_EEEE_EEEE) begin
            miscompares++; $display("FAIL zero_data_retained: got %h want eeeeeeeeeeeeeeee", out_data);
        end
    endtask

    task automatic test_hold;
        int lat;
        int bad;
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1; out_ready = 1'b0;
        step;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin step; if (out_valid === 1'b1) lat = i; end
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL hold_latency: got %0d want 4", lat); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom};
            #1;
            if (in_ready !== 1'b0) bad++;
            step;
            if (out_valid !== 1'b1 || out_data !== 64'hE4B1_79CA_D20F_8536) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_stall: got %0d bad cycles want 0", bad); end
        in_valid = 1'b0; out_ready = 1'b1;
        step;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got valid=%b want 0", out_valid); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin step; if (out_valid !== 1'b0 || busy !== 1'b0) bad++; end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_single_handshake: got %0d extra cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        int lat;
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin step; if (out_valid === 1'b1) lat = i; end
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL b2b_first_latency: got %0d want 4", lat); end
        in_valid = 1'b1; in_data = 64'hFEDC_BA98_7654_3210;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        vectors++; if (out_data !== 64'hE4B1_79CA_D20F_8536) begin
            miscompares++; $display("FAIL b2b_first_data: got %h want e4b179cad20f8536", out_data);
        end
        step;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_reload: got valid=%b busy=%b want 0 1", out_valid, busy);
        end
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin step; if (out_valid === 1'b1) lat = i; end
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL b2b_second_latency: got %0d want 4", lat); end
        vectors++; if (out_data !== 64'h6358_F02D_AC97_1B4E) begin
            miscompares++; $display("FAIL b2b_second_data: got %h want 6358f02dac971b4e", out_data);
        end
        step;
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int seen;
        logic [63:0] d;
        in_data = {$urandom, $urandom}; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        step; step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_reset: got valid=%b data=%h busy=%b ready=%b want 0 0 0 1", out_valid, out_data, busy, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin step; if (out_valid !== 1'b0) seen++; end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrun_discard: got %0d valid cycles want 0", seen); end
        d = {$urandom, $urandom};
        in_data = d; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin step; if (out_valid === 1'b1) lat = i; end
        vectors++; if (lat != 4 || out_data !== model(d)) begin
            miscompares++; $display("FAIL midrun_next_block: got lat=%0d data=%h want 4 %h", lat, out_data, model(d));
        end
        step;
    endtask

    task automatic test_lanes_variants;
        int lat1, lat16;
        logic [63:0] d1, d16;
        v1_in_data = 64'h0123_4567_89AB_CDEF; v16_in_data = 64'h0123_4567_89AB_CDEF;
        v1_in_valid = 1'b1; v16_in_valid = 1'b1; v1_out_ready = 1'b1; v16_out_ready = 1'b1;
        step;
        v1_in_valid = 1'b0; v16_in_valid = 1'b0;
        lat1 = 0; lat16 = 0; d1 = '0; d16 = '0;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (v1_out_valid === 1'b1 && lat1 == 0) begin lat1 = i; d1 = v1_out_data; end
            if (v16_out_valid === 1'b1 && lat16 == 0) begin lat16 = i; d16 = v16_out_data; end
        end
        vectors++; if (lat1 != 16) begin miscompares++; $display("FAIL lanes1_latency: got %0d want 16", lat1); end
        vectors++; if (d1 !== 64'hE4B1_79CA_D20F_8536) begin miscompares++; $display("FAIL lanes1_data: got %h want e4b179cad20f8536", d1); end
        vectors++; if (lat16 != 1) begin miscompares++; $display("FAIL lanes16_latency: got %0d want 1", lat16); end
        vectors++; if (d16 !== 64'hE4B1_79CA_D20F_8536) begin miscompares++; $display("FAIL lanes16_data: got %h want e4b179cad20f8536", d16); end
    endtask

    task automatic test_random;
        logic [63:0] exp_q[$];
        logic [63:0] d, data_prev;
        logic        hold_prev;
        int          sent, got, cycles;
        sent = 0; got = 0; cycles = 0; hold_prev = 1'b0; data_prev = '0;
        while (got < 1000 && cycles < 40000) begin
            if (hold_prev) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== data_prev) begin
                    miscompares++; $display("FAIL random_stall_stable: got valid=%b data=%h want 1 %h", out_valid, out_data, data_prev);
                end
            end
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (in_valid && in_ready) begin exp_q.push_back(model(in_data)); sent++; end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL random_extra_output: got %h want no output", out_data);
                end else begin
                    d = exp_q.pop_front();
                    if (out_data !== d) begin miscompares++; $display("FAIL random_data: got %h want %h", out_data, d); end
                end
                got++;
            end
            hold_prev = out_valid && !out_ready;
            data_prev = out_data;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++;
        if (got != 1000 || sent != got || exp_q.size() != 0) begin
            miscompares++; $display("FAIL random_count: got sent=%0d received=%0d pending=%0d want 1000 1000 0", sent, got, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_hold;
        test_back_to_back;
        test_reset_mid_run;
        test_lanes_variants;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
